// File: rtl/riscv_pkg.sv
// Shared RV32I definitions used by the fetch stage.
package riscv_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // One fetched instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetch entries with flush. DEPTH must be a power of two.
// The head entry is presented combinationally; it is meaningless while o_empty is set.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_push,
  input  fetch_entry_t            i_push_data,
  input  logic                    i_pop,
  input  logic                    i_flush,
  output fetch_entry_t            o_head,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic                    o_full,
  output logic                    o_empty
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t    r_mem [DEPTH];
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW:0]     r_count;
  logic            w_do_push;
  logic            w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Pointer and count bookkeeping; flush empties the FIFO and overrides push/pop.
  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents need no reset because the count qualifies them.
  always_ff @(posedge clk) begin
    if (rst_n && !i_flush && w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  // Upstream credit accounting must make an unmatched push into a full FIFO impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_push && o_full && !i_pop && !i_flush));

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction fetch: owns the PC, issues credit-limited in-order imem
// requests, tags responses with their PC and queues them for decode.
// EX redirects flush all wrong-path state and discard stale responses.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              QDEPTH   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [XLEN-1:0]    if_pc
);

  localparam int            CW         = $clog2(QDEPTH) + 1;
  localparam logic [CW:0]   CREDIT_MAX = (CW+1)'(QDEPTH);

  logic [XLEN-1:0] r_pc;
  logic [CW-1:0]   r_inflight;
  logic [CW-1:0]   r_drop;

  fetch_entry_t    w_iq_head;
  fetch_entry_t    w_iq_push_data;
  logic [CW-1:0]   w_iq_count;
  logic            w_iq_full;
  logic            w_iq_empty;
  logic            w_iq_has;

  fetch_entry_t    w_pcq_head;
  fetch_entry_t    w_pcq_push_data;
  logic [CW-1:0]   w_pcq_count;
  logic            w_pcq_full;
  logic            w_pcq_empty;

  logic            w_req_fire;
  logic            w_rsp_keep;
  logic            w_deq;
  logic [CW:0]     w_credit_used;
  logic            w_unused;

  assign w_iq_has = rst_n && !w_iq_empty;
  assign if_valid = w_iq_has && !redirect_valid;
  assign if_instr = w_iq_has ? w_iq_head.instr : '0;
  assign if_pc    = w_iq_has ? w_iq_head.pc    : '0;
  assign w_deq    = if_valid && if_ready;

  // Occupancy is counted after this cycle's dequeue: that slot is free by the
  // time any new response can land, which keeps one fetch per cycle sustainable.
  assign w_credit_used  = {1'b0, r_inflight} + {1'b0, w_iq_count} - {{CW{1'b0}}, w_deq};
  assign imem_req_valid = rst_n && !redirect_valid && (w_credit_used < CREDIT_MAX);
  assign imem_req_addr  = r_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  // Responses still owed to pre-redirect requests, or arriving alongside a redirect, are dropped.
  assign w_rsp_keep = imem_rsp_valid && (r_drop == '0) && !redirect_valid;

  assign w_pcq_push_data = '{pc: r_pc, instr: '0};
  assign w_iq_push_data  = '{pc: w_pcq_head.pc, instr: imem_rsp_data};

  fetch_queue #(.DEPTH(QDEPTH)) u_pc_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_req_fire),
    .i_push_data (w_pcq_push_data),
    .i_pop       (w_rsp_keep),
    .i_flush     (redirect_valid),
    .o_head      (w_pcq_head),
    .o_count     (w_pcq_count),
    .o_full      (w_pcq_full),
    .o_empty     (w_pcq_empty)
  );

  fetch_queue #(.DEPTH(QDEPTH)) u_instr_q (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_rsp_keep),
    .i_push_data (w_iq_push_data),
    .i_pop       (w_deq),
    .i_flush     (redirect_valid),
    .o_head      (w_iq_head),
    .o_count     (w_iq_count),
    .o_full      (w_iq_full),
    .o_empty     (w_iq_empty)
  );

  assign w_unused = ^{w_pcq_head.instr, w_pcq_count, w_pcq_full, w_pcq_empty, w_iq_full};

  // Fetch PC: redirect target (forced word-aligned) beats sequential advance.
  always_ff @(posedge clk) begin
    if (!rst_n)              r_pc <= RESET_PC;
    else if (redirect_valid) r_pc <= {redirect_pc[XLEN-1:2], 2'b00};
    else if (w_req_fire)     r_pc <= r_pc + XLEN'(4);
  end

  // Outstanding request count and number of stale responses left to discard.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_inflight <= '0;
      r_drop     <= '0;
    end else begin
      r_inflight <= r_inflight + CW'(w_req_fire) - CW'(imem_rsp_valid);
      if (redirect_valid)
        r_drop <= r_inflight - CW'(imem_rsp_valid);
      else if (imem_rsp_valid && (r_drop != '0))
        r_drop <= r_drop - CW'(1);
    end
  end

endmodule
